i2c_codec_responder: RTL

Synthesizable I2C write-only target that models the audio codec's control port: the responder end of the `i2c_av_config` initiator. It accepts the codec's 3-byte register writes, ACKs them, and keeps a shadow register file. It also reports each committed write. It sits beside `i2c_av_config` in loopback/self-test builds, with its SDA output wired-AND onto the shared `AUD_I2C_SDAT` line, so configuration traffic can be checked on hardware and in simulation without the codec.

---
 rtl/i2c_codec_pkg.sv | 24 ++
 rtl/i2c_line_sync.sv | 58 +++++
 rtl/i2c_codec_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_codec_pkg.sv
// i2c_codec_pkg: shared types and constants for the audio codec I2C
// responder (write-only control port model).
//   state_t          - protocol FSM states
//   DATA_W           - codec register data width (9 bits)
//   DEFAULT_DEV_ADDR - 7-bit target address of the codec (write byte 0x34)
//   CODEC_RESET_REG  - register address whose write resets the codec
package i2c_codec_pkg;

    localparam int         DATA_W           = 9;
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;
    localparam logic [6:0] CODEC_RESET_REG  = 7'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG_HI,
        ST_HI_ACK,
        ST_REG_LO,
        ST_LO_ACK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: two-flop synchronizers for SCL/SDA plus edge and bus
// condition detection against the previous synchronized sample.
//   clk       in  - system clock
//   scl_in    in  - raw SCL line
//   sda_in    in  - raw SDA line
//   scl_rise  out - synchronized SCL rose this cycle
//   scl_fall  out - synchronized SCL fell this cycle
//   start_det out - SDA fell while SCL high
//   stop_det  out - SDA rose while SCL high
//   sda       out - synchronized SDA
module i2c_line_sync (
    input  logic clk,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda
);

    // Bit 0 = SCL, bit 1 = SDA.
    logic [1:0] line_in;
    logic [1:0] sync_vec;
    logic [1:0] prev_vec;

    assign line_in = {sda_in, scl_in};

    // The chain carries no reset: a reset pulse in the middle of a transfer
    // must not fabricate line edges (and thus a false START) when the chain
    // would otherwise be forced to an idle value that disagrees with the bus.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;

            always_ff @(posedge clk) begin
                meta_reg <= line_in[gi];
                sync_reg <= meta_reg;
                prev_reg <= sync_reg;
            end

            assign sync_vec[gi] = sync_reg;
            assign prev_vec[gi] = prev_reg;
        end
    endgenerate

    assign scl_rise  = sync_vec[0] & ~prev_vec[0];
    assign scl_fall  = ~sync_vec[0] & prev_vec[0];
    // SCL must be high in both samples so an SDA change that coincides with
    // an SCL edge is never mistaken for a bus condition.
    assign start_det = sync_vec[0] & prev_vec[0] & prev_vec[1] & ~sync_vec[1];
    assign stop_det  = sync_vec[0] & prev_vec[0] & ~prev_vec[1] & sync_vec[1];
    assign sda       = sync_vec[1];

endmodule

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: write-only I2C target modelling the audio codec
// control port. Accepts 3-byte writes {addr+W, reg[6:0]+data[8], data[7:0]},
// ACKs them, keeps a shadow register file and reports each committed write.
//   clk         in  - system clock
//   reset       in  - synchronous active-high reset
//   i2c_sclk    in  - SCL from the initiator
//   i2c_sdat_in in  - sampled SDA line
//   i2c_sdat_oe out - 1 = pull SDA low
//   wr_strobe   out - one-cycle pulse per committed write
//   wr_addr     out - register address of the last committed write
//   wr_data     out - data of the last committed write
//   rd_addr     in  - shadow register select
//   rd_data     out - shadow register contents, one cycle after rd_addr
//   busy        out - FSM not idle
module i2c_codec_responder
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
    parameter int         NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i2c_sclk,
    input  logic              i2c_sdat_in,
    output logic              i2c_sdat_oe,
    output logic              wr_strobe,
    output logic [6:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .scl_in    (i2c_sclk),
        .sda_in    (i2c_sdat_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda       (sda)
    );

    state_t              state_reg, state_next;
    logic [3:0]          bit_cnt_reg, bit_cnt_next;
    logic [7:0]          shift_reg, shift_next;
    logic [6:0]          reg_addr_reg, reg_addr_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                oe_reg, oe_next;
    logic                commit;
    logic                wr_strobe_reg;
    logic [6:0]          wr_addr_reg;
    logic [DATA_W-1:0]   wr_data_reg;
    logic [DATA_W-1:0]   rd_data_reg;
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        reg_addr_next = reg_addr_reg;
        data_next     = data_reg;
        oe_next       = oe_reg;
        commit        = 1'b0;

        if (stop_det) begin
            state_next = ST_IDLE;
            oe_next    = 1'b0;
        end else if (start_det) begin
            state_next   = ST_ADDR;
            bit_cnt_next = '0;
            oe_next      = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR, ST_REG_HI, ST_REG_LO: begin
                    if (scl_rise && bit_cnt_reg != 4'd8) begin
                        shift_next   = {shift_reg[6:0], sda};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        // The fall ending bit 8 opens the ACK slot.
                        bit_cnt_next = '0;
                        if (state_reg == ST_ADDR) begin
                            if (shift_reg == {DEV_ADDR, 1'b0}) begin
                                state_next = ST_ADDR_ACK;
                                oe_next    = 1'b1;
                            end else begin
                                state_next = ST_IGNORE;
                            end
                        end else if (state_reg == ST_REG_HI) begin
                            reg_addr_next = shift_reg[7:1];
                            data_next     = {shift_reg[0], data_reg[7:0]};
                            state_next    = ST_HI_ACK;
                            oe_next       = 1'b1;
                        end else begin
                            data_next  = {data_reg[8], shift_reg};
                            state_next = ST_LO_ACK;
                            oe_next    = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        state_next = ST_REG_HI;
                        oe_next    = 1'b0;
                    end
                end
                ST_HI_ACK: begin
                    if (scl_fall) begin
                        state_next = ST_REG_LO;
                        oe_next    = 1'b0;
                    end
                end
                ST_LO_ACK: begin
                    // No auto-increment: later bytes land in IGNORE unACKed.
                    if (scl_fall) begin
                        state_next = ST_IGNORE;
                        oe_next    = 1'b0;
                        commit     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            reg_addr_reg  <= '0;
            data_reg      <= '0;
            oe_reg        <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            rd_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            reg_addr_reg  <= reg_addr_next;
            data_reg      <= data_next;
            oe_reg        <= oe_next;
            wr_strobe_reg <= commit;
            if (commit) begin
                wr_addr_reg <= reg_addr_reg;
                wr_data_reg <= data_reg;
            end
            // Reads the pre-commit contents when a write lands the same cycle.
            rd_data_reg <= shadow_q[rd_addr];
        end
    end

    // Shadow registers live in flops: a codec-reset write must clear every
    // entry in a single cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_shadow
            logic [DATA_W-1:0] value_reg;

            always_ff @(posedge clk) begin
                if (reset || (commit && reg_addr_reg == CODEC_RESET_REG)) begin
                    value_reg <= '0;
                end else if (commit && reg_addr_reg == 7'(gi)) begin
                    value_reg <= data_reg;
                end
            end

            assign shadow_q[gi] = value_reg;
        end
    endgenerate

    assign i2c_sdat_oe = oe_reg;
    assign wr_strobe   = wr_strobe_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign rd_data     = rd_data_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule
